// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding-mux selects
// and the multi-cycle execute FSM state type.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/mc_stall_fsm.sv
// Multi-cycle execute sequencer: holds E for MC_LAT-1 cycles after a start pulse.
// done marks the last BUSY cycle, on which the result leaves E.
module mc_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    mc_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = CW'(MC_LAT - 2);
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == BUSY);
    assign done = busy && (cnt_reg == '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard/interlock controller for the 5-stage pipeline: E-stage forwarding selects,
// load-use / RAW stalls, branch flushes and multi-cycle execute stall sequencing.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int FWD_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteEnE,
    input  logic              MemReadEnE,
    input  logic              McStartE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteEnM,
    input  logic              RegWriteEnW,
    input  logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              McBusy
);

    logic active_reg;
    logic active;
    logic mc_busy;
    logic mc_done;
    logic lu;
    logic raw;
    logic hazard_d;

    // Outputs stay quiet while rst is low and for one cycle after release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active_reg <= 1'b0;
        end else begin
            active_reg <= 1'b1;
        end
    end

    assign active = rst && active_reg;

    mc_stall_fsm #(
        .MC_LAT(MC_LAT)
    ) u_mc_fsm (
        .clk  (clk),
        .rst  (rst),
        .start(active && McStartE),
        .busy (mc_busy),
        .done (mc_done)
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic [REG_AW-1:0] rs_e;
            logic [REG_AW-1:0] rs_d;
            logic [1:0]        sel;
            logic              lu_hit;
            logic              raw_hit;

            assign rs_e = (gi == 0) ? Rs1E : Rs2E;
            assign rs_d = (gi == 0) ? Rs1D : Rs2D;

            // M holds the younger write, so it wins over W.
            always_comb begin
                sel = FWD_RF;
                if (RegWriteEnM && (RdM != '0) && (RdM == rs_e)) begin
                    sel = FWD_M;
                end else if (RegWriteEnW && (RdW != '0) && (RdW == rs_e)) begin
                    sel = FWD_W;
                end
            end

            assign lu_hit  = MemReadEnE && (RdE != '0) && (RdE == rs_d);
            assign raw_hit = (RegWriteEnE && (RdE != '0) && (RdE == rs_d))
                          || (RegWriteEnM && (RdM != '0) && (RdM == rs_d))
                          || (RegWriteEnW && (RdW != '0) && (RdW == rs_d));
        end
    endgenerate

    assign lu       = g_opnd[0].lu_hit  || g_opnd[1].lu_hit;
    assign raw      = g_opnd[0].raw_hit || g_opnd[1].raw_hit;
    assign hazard_d = (FWD_EN != 0) ? lu : raw;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        McBusy    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (active) begin
            if (FWD_EN != 0) begin
                ForwardAE = g_opnd[0].sel;
                ForwardBE = g_opnd[1].sel;
            end
            // A taken branch makes the stalled D instruction wrong-path, so flush beats stall.
            if (mc_busy) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
                McBusy = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (hazard_d) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    a_one_e_instr : assert property (@(posedge clk) disable iff (!rst) !(McStartE && PCSrcE));
    a_done_leaves : assert property (@(posedge clk) disable iff (!rst) mc_done |=> !mc_busy);

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one forwarding build and one pure-interlock build
// share the same stimulus; each task checks its own scenario inline.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteEnE, MemReadEnE, McStartE, RegWriteEnM, RegWriteEnW, PCSrcE;

    logic       StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, McBusy1;
    logic [1:0] ForwardAE1, ForwardBE1;
    logic       StallF0, StallD0, StallE0, FlushD0, FlushE0, FlushM0, McBusy0;
    logic [1:0] ForwardAE0, ForwardBE0;

    // {StallF,StallD,StallE,FlushD,FlushE,FlushM,McBusy}
    wire [6:0] ctl1 = {StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, McBusy1};
    wire [6:0] ctl0 = {StallF0, StallD0, StallE0, FlushD0, FlushE0, FlushM0, McBusy0};
    wire [3:0] fwd1 = {ForwardAE1, ForwardBE1};
    wire [3:0] fwd0 = {ForwardAE0, ForwardBE0};

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_STL  = 7'b1100100;
    localparam logic [6:0] C_BUSY = 7'b1110011;
    localparam logic [6:0] C_BR   = 7'b0001100;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(5), .MC_LAT(4), .FWD_EN(1)) dut_fwd (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteEnE(RegWriteEnE), .MemReadEnE(MemReadEnE), .McStartE(McStartE),
        .RdM(RdM), .RdW(RdW), .RegWriteEnM(RegWriteEnM), .RegWriteEnW(RegWriteEnW),
        .PCSrcE(PCSrcE), .StallF(StallF1), .StallD(StallD1), .StallE(StallE1),
        .FlushD(FlushD1), .FlushE(FlushE1), .FlushM(FlushM1),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1), .McBusy(McBusy1)
    );

    hazard_ctrl_unit #(.REG_AW(5), .MC_LAT(4), .FWD_EN(0)) dut_ilk (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteEnE(RegWriteEnE), .MemReadEnE(MemReadEnE), .McStartE(McStartE),
        .RdM(RdM), .RdW(RdW), .RegWriteEnM(RegWriteEnM), .RegWriteEnW(RegWriteEnW),
        .PCSrcE(PCSrcE), .StallF(StallF0), .StallD(StallD0), .StallE(StallE0),
        .FlushD(FlushD0), .FlushE(FlushE0), .FlushM(FlushM0),
        .ForwardAE(ForwardAE0), .ForwardBE(ForwardBE0), .McBusy(McBusy0)
    );

    task automatic clear_inputs;
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteEnE = 1'b0; MemReadEnE = 1'b0; McStartE = 1'b0;
        RegWriteEnM = 1'b0; RegWriteEnW = 1'b0; PCSrcE = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        RegWriteEnM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (ctl1 !== C_IDLE || fwd1 !== 4'b0000) begin
            n_fail++; $display("FAIL reset_low ctl=%b fwd=%b exp ctl=%b fwd=0000", ctl1, fwd1, C_IDLE);
        end else $display("[TB] reset_low ok");
        rst = 1'b1;
        #1;
        n_tests++;
        if (ctl1 !== C_IDLE || fwd1 !== 4'b0000) begin
            n_fail++; $display("FAIL reset_after ctl=%b fwd=%b exp ctl=%b fwd=0000", ctl1, fwd1, C_IDLE);
        end else $display("[TB] reset_after ok");
        tick();
        n_tests++;
        if (fwd1 !== 4'b1000 || fwd0 !== 4'b0000) begin
            n_fail++; $display("FAIL reset_release fwd1=%b fwd0=%b exp 1000/0000", fwd1, fwd0);
        end else $display("[TB] reset_release ok");
    endtask

    task automatic test_forward;
        clear_inputs();
        RegWriteEnM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        #1;
        n_tests++;
        if (ForwardAE1 !== 2'b10) begin
            n_fail++; $display("FAIL fwd_m got=%b exp=10", ForwardAE1);
        end else $display("[TB] fwd_m ok");
        RegWriteEnM = 1'b0; RdM = 5'd0; RegWriteEnW = 1'b1; RdW = 5'd5;
        #1;
        n_tests++;
        if (ForwardAE1 !== 2'b01) begin
            n_fail++; $display("FAIL fwd_w got=%b exp=01", ForwardAE1);
        end else $display("[TB] fwd_w ok");
        RegWriteEnM = 1'b1; RdM = 5'd5;
        #1;
        n_tests++;
        if (ForwardAE1 !== 2'b10 || ForwardAE0 !== 2'b00) begin
            n_fail++; $display("FAIL fwd_both fwd=%b/%b exp=10/00", ForwardAE1, ForwardAE0);
        end else $display("[TB] fwd_both ok");
        clear_inputs();
        RegWriteEnM = 1'b1; RdM = 5'd4; RegWriteEnW = 1'b1; RdW = 5'd9;
        Rs1E = 5'd9; Rs2E = 5'd4;
        #1;
        n_tests++;
        if (fwd1 !== 4'b0110) begin
            n_fail++; $display("FAIL fwd_split got=%b exp=0110", fwd1);
        end else $display("[TB] fwd_split ok");
    endtask

    task automatic test_x0;
        clear_inputs();
        MemReadEnE = 1'b1; RegWriteEnE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        RegWriteEnM = 1'b1; RdM = 5'd0; Rs1E = 5'd0;
        #1;
        n_tests++;
        if (ctl1 !== C_IDLE || ForwardAE1 !== 2'b00 || ctl0 !== C_IDLE) begin
            n_fail++; $display("FAIL x0 ctl1=%b ctl0=%b fwdA=%b exp %b %b 00", ctl1, ctl0, ForwardAE1, C_IDLE, C_IDLE);
        end else $display("[TB] x0 ok");
    endtask

    task automatic test_load_use;
        clear_inputs();
        MemReadEnE = 1'b1; RegWriteEnE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        n_tests++;
        if (ctl1 !== C_STL) begin
            n_fail++; $display("FAIL lu_stall got=%b exp=%b", ctl1, C_STL);
        end else $display("[TB] lu_stall ok");
        tick();
        // load now in W, dependent instruction in E behind a bubble in M
        clear_inputs();
        RegWriteEnW = 1'b1; RdW = 5'd7; Rs2E = 5'd7;
        #1;
        n_tests++;
        if (ctl1 !== C_IDLE || ForwardBE1 !== 2'b01) begin
            n_fail++; $display("FAIL lu_after ctl=%b fwdB=%b exp %b 01", ctl1, ForwardBE1, C_IDLE);
        end else $display("[TB] lu_after ok");
    endtask

    task automatic test_multicycle;
        clear_inputs();
        McStartE = 1'b1;
        #1;
        n_tests++;
        if (ctl1 !== C_IDLE) begin
            n_fail++; $display("FAIL mc_start got=%b exp=%b", ctl1, C_IDLE);
        end else $display("[TB] mc_start ok");
        tick();
        McStartE = 1'b0; PCSrcE = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (ctl1 !== C_BUSY || ctl0 !== C_BUSY) begin
                n_fail++; $display("FAIL mc_busy%0d ctl1=%b ctl0=%b exp=%b", i, ctl1, ctl0, C_BUSY);
            end else $display("[TB] mc_busy%0d ok", i);
            tick();
        end
        PCSrcE = 1'b0;
        #1;
        n_tests++;
        if (ctl1 !== C_IDLE || ctl0 !== C_IDLE) begin
            n_fail++; $display("FAIL mc_done ctl1=%b ctl0=%b exp=%b", ctl1, ctl0, C_IDLE);
        end else $display("[TB] mc_done ok");
    endtask

    task automatic test_branch;
        clear_inputs();
        PCSrcE = 1'b1;
        #1;
        n_tests++;
        if (ctl1 !== C_BR) begin
            n_fail++; $display("FAIL branch got=%b exp=%b", ctl1, C_BR);
        end else $display("[TB] branch ok");
        MemReadEnE = 1'b1; RegWriteEnE = 1'b1; RdE = 5'd12; Rs1D = 5'd12;
        #1;
        n_tests++;
        if (ctl1 !== C_BR || ctl0 !== C_BR) begin
            n_fail++; $display("FAIL branch_lu ctl1=%b ctl0=%b exp=%b", ctl1, ctl0, C_BR);
        end else $display("[TB] branch_lu ok");
        tick();
        clear_inputs();
    endtask

    task automatic test_interlock;
        logic [6:0] exp0;
        clear_inputs();
        Rs1D = 5'd3;
        for (int c = 0; c < 4; c++) begin
            RegWriteEnE = (c == 0); RdE = (c == 0) ? 5'd3 : 5'd0;
            RegWriteEnM = (c == 1); RdM = (c == 1) ? 5'd3 : 5'd0;
            RegWriteEnW = (c == 2); RdW = (c == 2) ? 5'd3 : 5'd0;
            exp0 = (c < 3) ? C_STL : C_IDLE;
            #1;
            n_tests++;
            if (ctl0 !== exp0 || ctl1 !== C_IDLE) begin
                n_fail++; $display("FAIL ilk_c%0d ctl0=%b ctl1=%b exp %b %b", c, ctl0, ctl1, exp0, C_IDLE);
            end else $display("[TB] ilk_c%0d ok", c);
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_busy;
        clear_inputs();
        McStartE = 1'b1;
        tick();
        McStartE = 1'b0;
        #1;
        n_tests++;
        if (ctl1 !== C_BUSY) begin
            n_fail++; $display("FAIL rmb_busy got=%b exp=%b", ctl1, C_BUSY);
        end else $display("[TB] rmb_busy ok");
        rst = 1'b0;
        #1;
        n_tests++;
        if (ctl1 !== C_IDLE || ctl0 !== C_IDLE) begin
            n_fail++; $display("FAIL rmb_low ctl1=%b ctl0=%b exp=%b", ctl1, ctl0, C_IDLE);
        end else $display("[TB] rmb_low ok");
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (ctl1 !== C_IDLE || ctl0 !== C_IDLE) begin
            n_fail++; $display("FAIL rmb_abort ctl1=%b ctl0=%b exp=%b", ctl1, ctl0, C_IDLE);
        end else $display("[TB] rmb_abort ok");
        RegWriteEnM = 1'b1; RdM = 5'd6; Rs2E = 5'd6;
        #1;
        n_tests++;
        if (ForwardBE1 !== 2'b10) begin
            n_fail++; $display("FAIL rmb_live got=%b exp=10", ForwardBE1);
        end else $display("[TB] rmb_live ok");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forward();
        test_x0();
        test_load_use();
        test_multicycle();
        test_branch();
        test_interlock();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
